// File: rtl/seg_msg_arbiter.sv
// Display arbiter for the shared 8-digit seven-segment word.
// Picks alarm, flash or level source and holds each grant a minimum time.
module seg_msg_arbiter #(
   parameter int unsigned MIN_HOLD  = 25_000_000,
   parameter int unsigned FLASH_CYC = 100_000_000,
   parameter int unsigned CNT_W     = 27
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic        flash_stb,
   input  logic [31:0] flash_data,
   input  logic        blank,
   output logic [31:0] disp_data,
   output logic [2:0]  grant,
   output logic        flash_active
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_FLASH = 2'd2
   } state_e;

   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(MIN_HOLD - 1);
   localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYC - 1);
   localparam logic [31:0]      BLANK_W  = 32'hFFFF_FFFF;

   state_e             state_q, state_d;
   logic [1:0]         src_q, src_d;
   logic [CNT_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]   fcnt_q, fcnt_d;
   logic               pend_q, pend_d;
   logic [31:0]        fbuf_q, fbuf_d;
   logic [31:0]        word_q, word_d;
   logic [31:0]        disp_q, disp_d;
   logic [2:0]         grant_q, grant_d;
   logic               fact_q, fact_d;

   logic               pend_eff;
   state_e             arb_state;
   logic [1:0]         arb_src;
   logic               req_k;
   logic               req_n;
   logic [31:0]        data_n;

   assign pend_eff = pend_q | flash_stb;

   // Idle-style arbitration: alarm > flash > source 1 > source 2.
   always_comb begin
      arb_state = S_IDLE;
      arb_src   = 2'd0;
      if (req[0]) begin
         arb_state = S_GRANT;
         arb_src   = 2'd0;
      end else if (pend_eff) begin
         arb_state = S_FLASH;
      end else if (req[1]) begin
         arb_state = S_GRANT;
         arb_src   = 2'd1;
      end else if (req[2]) begin
         arb_state = S_GRANT;
         arb_src   = 2'd2;
      end
   end

   always_comb begin
      unique case (src_q)
         2'd0:    req_k = req[0];
         2'd1:    req_k = req[1];
         default: req_k = req[2];
      endcase
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      hold_d  = (hold_q != '0) ? hold_q - CNT_W'(1) : '0;
      fcnt_d  = fcnt_q;
      pend_d  = pend_q | (flash_stb & (state_q != S_FLASH));
      fbuf_d  = flash_stb ? flash_data : fbuf_q;
      case (state_q)
         S_IDLE: begin
            state_d = arb_state;
            src_d   = arb_src;
         end
         S_GRANT: begin
            if (req[0] && src_q != 2'd0) begin
               src_d = 2'd0;
            end else if (pend_eff && src_q != 2'd0) begin
               state_d = S_FLASH;
            end else if (req[1] && src_q == 2'd2) begin
               src_d = 2'd1;
            end else if (!req_k && hold_q == '0) begin
               state_d = arb_state;
               src_d   = arb_src;
            end
         end
         S_FLASH: begin
            if (req[0]) begin
               state_d = S_GRANT;
               src_d   = 2'd0;
            end else if (flash_stb) begin
               fcnt_d = FLASH_LD;
            end else if (fcnt_q == '0) begin
               state_d = arb_state;
               src_d   = arb_src;
            end else begin
               fcnt_d = fcnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (state_d == S_GRANT &&
          (state_q != S_GRANT || src_d != src_q)) begin
         hold_d = HOLD_LD;
      end
      if (state_d == S_FLASH && state_q != S_FLASH) begin
         fcnt_d = FLASH_LD;
         pend_d = 1'b0;
      end
   end

   always_comb begin
      unique case (src_d)
         2'd0: begin
            req_n  = req[0];
            data_n = data0;
         end
         2'd1: begin
            req_n  = req[1];
            data_n = data1;
         end
         default: begin
            req_n  = req[2];
            data_n = data2;
         end
      endcase
   end

   // word_q keeps the unmasked word so blank never corrupts a frozen hold.
   always_comb begin
      word_d  = BLANK_W;
      grant_d = 3'b000;
      fact_d  = 1'b0;
      case (state_d)
         S_GRANT: begin
            word_d  = req_n ? data_n : word_q;
            grant_d = 3'b001 << src_d;
         end
         S_FLASH: begin
            word_d = fbuf_d;
            fact_d = 1'b1;
         end
         default: begin
            word_d = BLANK_W;
         end
      endcase
      disp_d = blank ? BLANK_W : word_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         src_q   <= 2'd0;
         hold_q  <= '0;
         fcnt_q  <= '0;
         pend_q  <= 1'b0;
         fbuf_q  <= '0;
         word_q  <= BLANK_W;
         disp_q  <= BLANK_W;
         grant_q <= 3'b000;
         fact_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         hold_q  <= hold_d;
         fcnt_q  <= fcnt_d;
         pend_q  <= pend_d;
         fbuf_q  <= fbuf_d;
         word_q  <= word_d;
         disp_q  <= disp_d;
         grant_q <= grant_d;
         fact_q  <= fact_d;
      end
   end

   assign disp_data    = disp_q;
   assign grant        = grant_q;
   assign flash_active = fact_q;

endmodule

// File: tb/tb_seg_msg_arbiter.sv
// Directed bench for seg_msg_arbiter with MIN_HOLD=4, FLASH_CYC=6.
// Expected outputs are queued per step and checked after the clock edge.
module tb_seg_msg_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic [31:0] data0, data1, data2;
   logic        flash_stb;
   logic [31:0] flash_data;
   logic        blank;
   logic [31:0] disp_data;
   logic [2:0]  grant;
   logic        flash_active;

   typedef struct {
      string       tag;
      logic [31:0] d;
      logic [2:0]  g;
      logic        f;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   localparam logic [31:0] BL  = 32'hFFFF_FFFF;
   localparam logic [31:0] D0  = 32'hFFFF_A1A7;
   localparam logic [31:0] D1A = 32'hFFFF_0B0B;
   localparam logic [31:0] D1B = 32'hFFFF_1B1B;
   localparam logic [31:0] D1C = 32'hFFFF_2C2C;
   localparam logic [31:0] D2  = 32'hFFFF_1234;

   seg_msg_arbiter #(
      .MIN_HOLD  (4),
      .FLASH_CYC (6),
      .CNT_W     (27)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .data0        (data0),
      .data1        (data1),
      .data2        (data2),
      .flash_stb    (flash_stb),
      .flash_data   (flash_data),
      .blank        (blank),
      .disp_data    (disp_data),
      .grant        (grant),
      .flash_active (flash_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input string tag, input logic [31:0] d,
                       input logic [2:0] g, input logic f);
      exp_t e;
      e.tag = tag;
      e.d   = d;
      e.g   = g;
      e.f   = f;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      assert (disp_data === e.d) else begin
         n_err++;
         $error("FAIL %s disp_data observed=%h expected=%h",
                e.tag, disp_data, e.d);
      end
      n_cmp++;
      assert (grant === e.g) else begin
         n_err++;
         $error("FAIL %s grant observed=%b expected=%b",
                e.tag, grant, e.g);
      end
      n_cmp++;
      assert (flash_active === e.f) else begin
         n_err++;
         $error("FAIL %s flash_active observed=%b expected=%b",
                e.tag, flash_active, e.f);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = 3'b110;
      data0      = D0;
      data1      = D1A;
      data2      = D2;
      flash_stb  = 1'b0;
      flash_data = 32'h0;
      blank      = 1'b0;

      // reset holds outputs despite requests
      tick("rst0", BL, 3'b000, 1'b0);
      tick("rst1", BL, 3'b000, 1'b0);
      rst_n = 1'b1;
      tick("rel", D1A, 3'b010, 1'b0);
      tick("g1", D1A, 3'b010, 1'b0);
      data1 = D1B;
      tick("track", D1B, 3'b010, 1'b0);
      tick("g1b", D1B, 3'b010, 1'b0);

      // preemption of source 2 by alarm with hold pending
      req = 3'b100;
      tick("g2", D2, 3'b100, 1'b0);
      req = 3'b101;
      tick("preempt", D0, 3'b001, 1'b0);
      req = 3'b000;
      for (int i = 0; i < 3; i++)
         tick("hold0", D0, 3'b001, 1'b0);
      tick("idle0", BL, 3'b000, 1'b0);

      // minimum hold, then fall to source 2
      req = 3'b110;
      tick("mh_T", D1B, 3'b010, 1'b0);
      req   = 3'b100;
      data1 = D1C;
      for (int i = 0; i < 3; i++)
         tick("mh_frz", D1B, 3'b010, 1'b0);
      tick("mh_g2", D2, 3'b100, 1'b0);
      req = 3'b000;
      for (int i = 0; i < 3; i++)
         tick("mh_hold2", D2, 3'b100, 1'b0);
      tick("idle1", BL, 3'b000, 1'b0);

      // plain flash
      flash_stb  = 1'b1;
      flash_data = 32'hFFFF_EAA0;
      tick("fl_in", 32'hFFFF_EAA0, 3'b000, 1'b1);
      flash_stb  = 1'b0;
      flash_data = 32'h1234_5678;
      for (int i = 0; i < 5; i++)
         tick("fl_on", 32'hFFFF_EAA0, 3'b000, 1'b1);
      tick("fl_end", BL, 3'b000, 1'b0);

      // alarm aborts a running flash, flash discarded
      flash_stb  = 1'b1;
      flash_data = 32'hFFFF_EAA1;
      tick("ab_in", 32'hFFFF_EAA1, 3'b000, 1'b1);
      flash_stb = 1'b0;
      tick("ab_on", 32'hFFFF_EAA1, 3'b000, 1'b1);
      req = 3'b001;
      tick("ab_alarm", D0, 3'b001, 1'b0);
      req = 3'b000;
      for (int i = 0; i < 3; i++)
         tick("ab_hold", D0, 3'b001, 1'b0);
      tick("ab_idle", BL, 3'b000, 1'b0);
      tick("ab_noflash", BL, 3'b000, 1'b0);

      // strobe with alarm queues the flash until the alarm ends
      req        = 3'b001;
      flash_stb  = 1'b1;
      flash_data = 32'hFFFF_EAA2;
      tick("q_alarm", D0, 3'b001, 1'b0);
      flash_stb  = 1'b0;
      flash_data = 32'h0;
      for (int i = 0; i < 3; i++)
         tick("q_held", D0, 3'b001, 1'b0);
      req = 3'b000;
      tick("q_fl_in", 32'hFFFF_EAA2, 3'b000, 1'b1);
      for (int i = 0; i < 5; i++)
         tick("q_fl_on", 32'hFFFF_EAA2, 3'b000, 1'b1);
      tick("q_idle", BL, 3'b000, 1'b0);

      // blank masks only the word
      blank = 1'b1;
      req   = 3'b010;
      tick("bl_on", BL, 3'b010, 1'b0);
      tick("bl_on2", BL, 3'b010, 1'b0);
      blank = 1'b0;
      tick("bl_off", D1C, 3'b010, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
